// File: rtl/pit_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pit_irq_pkg
// Description : Shared register addresses and FSM state type for the PIT
//               interrupt controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pit_irq_pkg;

    localparam logic [1:0] ADDR_MASK  = 2'd0;
    localparam logic [1:0] ADDR_FORCE = 2'd1;
    localparam logic [1:0] ADDR_CLEAR = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } pit_irq_state_t;

endpackage : pit_irq_pkg
`default_nettype wire

// File: rtl/pit_irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : pit_irq_prio_enc
// Description : Combinational fixed-priority encoder, lowest set index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_irq_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_vec,
    output logic [IDW-1:0] o_id,
    output logic           o_any
);

    // Scanning high-to-low lets the lowest set index overwrite last.
    always_comb begin
        o_id  = '0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_id  = IDW'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule : pit_irq_prio_enc
`default_nettype wire

// File: rtl/pit_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pit_irq_ctrl
// Description : Latches timer tick pulses into pending bits, masks them and
//               presents one prioritised level IRQ with source id to the host.
//               Optional miss counters / overrun flags: PIT_IRQ_OVERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pit_irq_ctrl
    import pit_irq_pkg::*;
#(
    parameter int  NUM_SRC = 4,
    parameter int  MISS_W  = 4,
    localparam int IDW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [7:0]         cfg_wdata,
    input  logic               ack,
    output logic               irq,
    output logic [IDW-1:0]     irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun
);

    pit_irq_state_t     r_state;
    pit_irq_state_t     w_state_nxt;
    logic [IDW-1:0]     r_irq_id;
    logic [IDW-1:0]     w_irq_id_nxt;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] r_mask;

    logic [NUM_SRC-1:0] w_wbits;
    logic [NUM_SRC-1:0] w_force;
    logic [NUM_SRC-1:0] w_clear;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_id_vec;
    logic [NUM_SRC-1:0] w_ack_clr;
    logic               w_ack_fire;
    logic               w_retract;
    logic [IDW-1:0]     w_enc_id;
    logic               w_enc_any;
    logic               w_unused_wdata;

    assign w_wbits        = cfg_wdata[NUM_SRC-1:0];
    assign w_unused_wdata = ^cfg_wdata;
    assign w_force        = (cfg_we && cfg_addr == ADDR_FORCE) ? w_wbits : '0;
    assign w_clear        = (cfg_we && cfg_addr == ADDR_CLEAR) ? w_wbits : '0;
    assign w_eligible     = r_pending & r_mask;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_id_vec
        assign w_id_vec[gi] = (r_irq_id == IDW'(gi));
    end

    assign w_ack_fire = ack && (r_state == ST_ASSERT);
    assign w_ack_clr  = w_ack_fire ? w_id_vec : '0;
    assign w_retract  = (r_state == ST_ASSERT) && |(w_clear & w_id_vec);

    // New ticks and FORCE are OR-ed in last so they beat CLEAR and ack.
    assign w_pending_nxt = (r_pending & ~(w_clear | w_ack_clr)) | src_pulse | w_force;

    pit_irq_prio_enc #(
        .N   (NUM_SRC),
        .IDW (IDW)
    ) u_prio_enc (
        .i_vec (w_eligible),
        .o_id  (w_enc_id),
        .o_any (w_enc_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (cfg_we && cfg_addr == ADDR_MASK) begin
                r_mask <= w_wbits;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_irq_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_irq_id <= w_irq_id_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_irq_id_nxt = r_irq_id;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_any) begin
                    w_state_nxt  = ST_ASSERT;
                    w_irq_id_nxt = w_enc_id;
                end
            end
            ST_ASSERT: begin
                // Masking the active source does not retract; only ack or CLEAR do.
                if (w_ack_fire || w_retract) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign irq     = (r_state == ST_ASSERT);
    assign irq_id  = r_irq_id;
    assign pending = r_pending;

`ifdef PIT_IRQ_OVERRUN_EN
    logic [MISS_W-1:0]  r_miss_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] r_overrun;
    logic [NUM_SRC-1:0] w_miss;

    assign w_miss = src_pulse & r_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_miss_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_clear[i]) begin
                    r_overrun[i] <= 1'b0;
                end else if (w_miss[i]) begin
                    r_overrun[i] <= 1'b1;
                end
                if (w_clear[i] || w_ack_clr[i]) begin
                    r_miss_cnt[i] <= '0;
                end else if (w_miss[i] && r_miss_cnt[i] != '1) begin
                    r_miss_cnt[i] <= r_miss_cnt[i] + MISS_W'(1);
                end
            end
        end
    end

    assign overrun = r_overrun;
`else
    logic [MISS_W-1:0] w_unused_miss;
    assign w_unused_miss = '0;
    assign overrun       = '0;
`endif

endmodule : pit_irq_ctrl
`default_nettype wire

// File: tb/tb_pit_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pit_irq_ctrl
// Description : Randomised self-checking bench for pit_irq_ctrl against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pit_irq_ctrl;

    localparam int NUM_SRC = 4;
    localparam int MISS_W  = 4;
    localparam int IDW     = 2;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_SRC-1:0] src_pulse;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [7:0]         cfg_wdata;
    logic               ack;
    logic               irq;
    logic [IDW-1:0]     irq_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit   [NUM_SRC-1:0] m_pend;
    bit   [NUM_SRC-1:0] m_mask;
    bit   [NUM_SRC-1:0] m_ovr;
    int                 m_miss [NUM_SRC];
    bit                 m_busy;
    int                 m_id;

    always #5 clk = ~clk;

    pit_irq_ctrl #(
        .NUM_SRC (NUM_SRC),
        .MISS_W  (MISS_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src_pulse (src_pulse),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .ack       (ack),
        .irq       (irq),
        .irq_id    (irq_id),
        .pending   (pending),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock of the specified behaviour, evaluated on the pre-edge state.
    task automatic model_step();
        bit [NUM_SRC-1:0] clr;
        bit [NUM_SRC-1:0] frc;
        bit [NUM_SRC-1:0] np;
        bit [NUM_SRC-1:0] elig;
        bit               acked;
        bit               miss;
        bit               done_src;
        if (reset) begin
            m_pend = '0; m_mask = '0; m_ovr = '0; m_busy = 0; m_id = 0;
            for (int i = 0; i < NUM_SRC; i++) m_miss[i] = 0;
            return;
        end
        clr   = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[NUM_SRC-1:0] : '0;
        frc   = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[NUM_SRC-1:0] : '0;
        acked = m_busy && ack;
        elig  = m_pend & m_mask;
        for (int i = 0; i < NUM_SRC; i++) begin
            miss     = src_pulse[i] && m_pend[i];
            done_src = acked && (m_id == i);
            np[i]    = m_pend[i];
            if (clr[i] || done_src) np[i] = 1'b0;
            if (src_pulse[i] || frc[i]) np[i] = 1'b1;
`ifdef PIT_IRQ_OVERRUN_EN
            if (clr[i]) m_ovr[i] = 1'b0;
            else if (miss) m_ovr[i] = 1'b1;
            if (clr[i] || done_src) m_miss[i] = 0;
            else if (miss && m_miss[i] < MISS_MAX) m_miss[i]++;
`else
            if (miss) m_ovr[i] = 1'b0;
`endif
        end
        if (m_busy) begin
            if (acked || clr[m_id]) m_busy = 0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (elig[i] && !m_busy) begin
                    m_busy = 1;
                    m_id   = i;
                end
            end
        end
        if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata[NUM_SRC-1:0];
        m_pend = np;
    endtask

    task automatic check_all();
        chk("irq", 32'(irq), 32'(m_busy));
        if (m_busy) chk("irq_id", 32'(irq_id), 32'(m_id));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cyc(input logic [NUM_SRC-1:0] p, input logic we, input logic [1:0] a,
                       input logic [7:0] wd, input logic k, input logic r);
        src_pulse = p; cfg_we = we; cfg_addr = a; cfg_wdata = wd; ack = k; reset = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 0, 2'd0, 8'h00, 0, 0);
    endtask

    initial begin
        reset = 1; src_pulse = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; ack = 0;
        #1;
        cyc('0, 0, 2'd0, 8'h00, 0, 1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_id", 32'(irq_id), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);

        // Basic tick on src 2
        cyc('0, 1, 2'd0, 8'h0F, 0, 0);
        cyc(4'h4, 0, 2'd0, 8'h00, 0, 0);
        chk("t1_pend", 32'(pending), 32'h4);
        chk("t1_irq", 32'(irq), 32'd0);
        idle(1);
        chk("t2_irq", 32'(irq), 32'd1);
        chk("t2_id", 32'(irq_id), 32'd2);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);
        chk("ack_irq", 32'(irq), 32'd0);
        chk("ack_pend", 32'(pending), 32'd0);

        // Simultaneous ticks, lowest index first
        cyc(4'hA, 0, 2'd0, 8'h00, 0, 0);
        idle(1);
        chk("pri_id1", 32'(irq_id), 32'd1);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);
        chk("pri_gap", 32'(irq), 32'd0);
        idle(1);
        chk("pri_irq3", 32'(irq), 32'd1);
        chk("pri_id3", 32'(irq_id), 32'd3);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);

        // Masked source stays pending, unmasking raises irq two cycles later
        cyc('0, 1, 2'd0, 8'h00, 0, 0);
        cyc(4'h1, 0, 2'd0, 8'h00, 0, 0);
        idle(2);
        chk("msk_pend", 32'(pending), 32'h1);
        chk("msk_irq", 32'(irq), 32'd0);
        cyc('0, 1, 2'd0, 8'h01, 0, 0);
        chk("unmsk_irq0", 32'(irq), 32'd0);
        idle(1);
        chk("unmsk_irq1", 32'(irq), 32'd1);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);

        // Retraction by CLEAR, then ack in IDLE is ignored
        cyc('0, 1, 2'd0, 8'h0F, 0, 0);
        cyc(4'h4, 0, 2'd0, 8'h00, 0, 0);
        idle(1);
        chk("ret_id", 32'(irq_id), 32'd2);
        cyc('0, 1, 2'd2, 8'h04, 0, 0);
        chk("ret_irq", 32'(irq), 32'd0);
        chk("ret_pend", 32'(pending), 32'd0);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);
        chk("idle_ack", 32'(irq), 32'd0);

        // Ack racing a new tick on the same source
        cyc(4'h4, 0, 2'd0, 8'h00, 0, 0);
        idle(1);
        cyc(4'h4, 0, 2'd0, 8'h00, 1, 0);
        chk("race_irq", 32'(irq), 32'd0);
        chk("race_pend", 32'(pending), 32'h4);
        idle(1);
        chk("race_re", 32'(irq), 32'd1);
        chk("race_id", 32'(irq_id), 32'd2);
        cyc('0, 0, 2'd0, 8'h00, 1, 0);

        // Repeated ticks without ack
        for (int i = 0; i < 20; i++) cyc(4'h1, 0, 2'd0, 8'h00, 0, 0);
`ifdef PIT_IRQ_OVERRUN_EN
        chk("ovr0", 32'(overrun[0]), 32'd1);
        chk("miss0", 32'(dut.r_miss_cnt[0]), 32'd15);
        cyc('0, 1, 2'd2, 8'h01, 0, 0);
        chk("ovr0_clr", 32'(overrun[0]), 32'd0);
        chk("miss0_clr", 32'(dut.r_miss_cnt[0]), 32'd0);
`else
        chk("ovr_off", 32'(overrun), 32'd0);
        cyc('0, 1, 2'd2, 8'h01, 0, 0);
`endif

        // Reset while asserted
        cyc(4'h2, 0, 2'd0, 8'h00, 0, 0);
        idle(1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        cyc('0, 0, 2'd0, 8'h00, 0, 1);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_pend", 32'(pending), 32'd0);
        cyc(4'h1, 0, 2'd0, 8'h00, 0, 0);
        idle(2);
        chk("mid_rst_mask", 32'(irq), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_SRC-1:0] p;
            for (int i = 0; i < NUM_SRC; i++) p[i] = ($urandom_range(0, 7) == 0);
            cyc(p,
                $urandom_range(0, 5) == 0,
                2'($urandom_range(0, 3)),
                8'($urandom),
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pit_irq_ctrl
`default_nettype wire
